// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the CPU-side SDRAM ext-bus bridge.
//   bridge_state_t  : bridge FSM states
//   BE_LO / BE_HI   : Avalon byteenable patterns for the low / high byte lane
//   RD_TIMEOUT_FILL : byte returned to the CPU when a read times out
package sdram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_WAIT,
    ACK,
    HOLD
  } bridge_state_t;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;

  localparam logic [7:0] RD_TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/sdram_ext_bridge.sv
// 8-bit CPU ext-bus to 16-bit pipelined Avalon-MM master bridge.
//
// Each held ext_read/ext_write request produces exactly one Avalon
// transaction and one ext_acknowledge pulse; the request must drop for a
// cycle before the next one is taken. Byte lane comes from ext_address[0].
// Reads that see no readdatavalid within TIMEOUT cycles complete with 8'hFF
// and set the sticky err_timeout flag.
//
// Ports:
//   clk_50, rst         : clock, synchronous active-high reset
//   ext_address         : CPU byte address
//   ext_read, ext_write : level requests, held by upstream (write wins)
//   ext_write_data      : write byte
//   ext_acknowledge     : one-cycle completion pulse
//   ext_read_data       : last read byte, stable until the next read completes
//   avm_*               : Avalon-MM master to the SDRAM controller
//   err_clr             : clears err_timeout (a simultaneous set wins)
//   err_timeout         : sticky read-timeout flag
module sdram_ext_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int AVM_ADDR_W = 24,
  parameter int BASE_WORD  = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_50,
  input  logic                  rst,
  input  logic [15:0]           ext_address,
  input  logic                  ext_read,
  input  logic                  ext_write,
  input  logic [7:0]            ext_write_data,
  output logic                  ext_acknowledge,
  output logic [7:0]            ext_read_data,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic [1:0]            avm_byteenable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [15:0]           avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [15:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  err_clr,
  output logic                  err_timeout
);

  localparam logic [7:0]            TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [AVM_ADDR_W-1:0] BASE_W  = AVM_ADDR_W'(BASE_WORD);

  bridge_state_t state, state_n;

  logic       is_write;
  logic       lane;
  logic [7:0] to_cnt;

  logic ext_req;
  logic cmd_accept;
  logic rd_expire;
  logic [AVM_ADDR_W-1:0] word_addr;

  assign ext_req    = ext_read | ext_write;
  assign cmd_accept = (state == CMD) && !avm_waitrequest;
  // Data arriving in the expiry cycle takes precedence over the timeout.
  assign rd_expire  = (state == RD_WAIT) && !avm_readdatavalid && (to_cnt == TO_LAST);
  assign word_addr  = BASE_W + AVM_ADDR_W'(ext_address[15:1]);

  // Commands and acknowledge are decodes of the state register, so a reset
  // drops them on the very next edge.
  assign avm_read        = (state == CMD) && !is_write;
  assign avm_write       = (state == CMD) &&  is_write;
  assign ext_acknowledge = (state == ACK);

  always_ff @(posedge clk_50) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ext_req) state_n = CMD;
      CMD:     if (!avm_waitrequest) state_n = is_write ? ACK : RD_WAIT;
      RD_WAIT: if (avm_readdatavalid || (to_cnt == TO_LAST)) state_n = ACK;
      ACK:     state_n = HOLD;
      HOLD:    if (!ext_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request capture and address/lane translation.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      is_write       <= 1'b0;
      lane           <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else if ((state == IDLE) && ext_req) begin
      is_write       <= ext_write;
      lane           <= ext_address[0];
      avm_address    <= word_addr;
      avm_byteenable <= ext_address[0] ? BE_HI : BE_LO;
      avm_writedata  <= {ext_write_data, ext_write_data};
    end
  end

  // Read-wait counter: cleared as the read command is accepted so the first
  // RD_WAIT cycle sees zero.
  always_ff @(posedge clk_50) begin
    if (rst)                   to_cnt <= '0;
    else if (cmd_accept)       to_cnt <= '0;
    else if (state == RD_WAIT) to_cnt <= to_cnt + 8'd1;
  end

  // Read data return; stray readdatavalid outside RD_WAIT is ignored.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      ext_read_data <= '0;
    end else if (state == RD_WAIT) begin
      if (avm_readdatavalid)
        ext_read_data <= lane ? avm_readdata[15:8] : avm_readdata[7:0];
      else if (to_cnt == TO_LAST)
        ext_read_data <= RD_TIMEOUT_FILL;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst)            err_timeout <= 1'b0;
    else if (rd_expire) err_timeout <= 1'b1;
    else if (err_clr)   err_timeout <= 1'b0;
  end

endmodule

// File: tb/tb_sdram_ext_bridge.sv
// Self-checking bench for sdram_ext_bridge (TIMEOUT=8): a table of single
// transactions plus hand-written hold, timeout and reset sequences.
module tb_sdram_ext_bridge;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [15:0] ext_address;
  logic        ext_read;
  logic        ext_write;
  logic [7:0]  ext_write_data;
  logic        ext_acknowledge;
  logic [7:0]  ext_read_data;
  logic [23:0] avm_address;
  logic [1:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        err_clr;
  logic        err_timeout;

  sdram_ext_bridge #(.AVM_ADDR_W(24), .BASE_WORD(0), .TIMEOUT(8)) dut (
    .clk_50            (clk_50),
    .rst               (rst),
    .ext_address       (ext_address),
    .ext_read          (ext_read),
    .ext_write         (ext_write),
    .ext_write_data    (ext_write_data),
    .ext_acknowledge   (ext_acknowledge),
    .ext_read_data     (ext_read_data),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .err_clr           (err_clr),
    .err_timeout       (err_timeout)
  );

  always #5 clk_50 = ~clk_50;

  int total = 0;
  int bad   = 0;

  // Event counters observed at each active edge.
  int ack_cnt = 0;
  int rd_acc  = 0;
  int wr_acc  = 0;
  always @(posedge clk_50) begin
    if (ext_acknowledge)               ack_cnt <= ack_cnt + 1;
    if (avm_read  && !avm_waitrequest) rd_acc  <= rd_acc + 1;
    if (avm_write && !avm_waitrequest) wr_acc  <= wr_acc + 1;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          wait_n;   // cycles of waitrequest high in CMD
    int          lat;      // RD_WAIT cycles before the valid cycle
    logic [15:0] rdata;
    logic [23:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd;
    logic        exp_write;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int a0, r0, w0;
    a0 = ack_cnt; r0 = rd_acc; w0 = wr_acc;
    ext_address     = v.addr;
    ext_write_data  = v.wd;
    ext_read        = v.rd;
    ext_write       = v.wr;
    avm_waitrequest = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(avm_read || avm_write) && n < 8);
    chk("cmd_start_lat", n, 1);
    chk("cmd_write", avm_write, v.exp_write);
    chk("cmd_read", avm_read, !v.exp_write);
    chk("cmd_addr", avm_address, v.exp_addr);
    chk("cmd_be", avm_byteenable, v.exp_be);
    chk("cmd_wdata", avm_writedata, v.exp_wd);
    n = 0;
    while ((avm_read || avm_write) && n < v.wait_n + 6) begin
      n++;
      avm_waitrequest = (n <= v.wait_n);
      tick();
    end
    avm_waitrequest = 1'b0;
    chk("cmd_cycles", n, v.wait_n + 1);
    if (!v.exp_write) begin
      for (int i = 0; i < v.lat; i++) begin
        chk("early_ack", ext_acknowledge, 1'b0);
        tick();
      end
      avm_readdatavalid = 1'b1;
      avm_readdata      = v.rdata;
      tick();
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'h0000;
    end
    chk("ack", ext_acknowledge, 1'b1);
    chk("rdata", ext_read_data, v.exp_rd);
    chk("err_clear", err_timeout, 1'b0);
    ext_read  = 1'b0;
    ext_write = 1'b0;
    tick();
    chk("ack_single", ext_acknowledge, 1'b0);
    tick();
    chk("ack_count", ack_cnt - a0, 1);
    chk("rd_accepts", rd_acc - r0, v.exp_write ? 0 : 1);
    chk("wr_accepts", wr_acc - w0, v.exp_write ? 1 : 0);
  endtask

  initial begin
    int n, a0, r0;
    logic stable;

    vecs[0] = '{1'b1, 1'b0, 16'h1235, 8'hA5, 3, 0, 16'h0000, 24'h00091A, 2'b10, 16'hA5A5, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'h1234, 8'h00, 0, 2, 16'hBEEF, 24'h00091A, 2'b01, 16'h0000, 1'b0, 8'hEF};
    vecs[2] = '{1'b0, 1'b1, 16'h1235, 8'h00, 1, 2, 16'hBEEF, 24'h00091A, 2'b10, 16'h0000, 1'b0, 8'hBE};
    vecs[3] = '{1'b1, 1'b1, 16'h0010, 8'h3C, 0, 0, 16'h0000, 24'h000008, 2'b01, 16'h3C3C, 1'b1, 8'hBE};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h5A, 0, 0, 16'h0000, 24'h007FFF, 2'b10, 16'h5A5A, 1'b1, 8'hBE};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, 1, 0, 16'h1234, 24'h007FFF, 2'b01, 16'h0000, 1'b0, 8'h34};
    vecs[6] = '{1'b0, 1'b1, 16'h0006, 8'h00, 0, 7, 16'h00C3, 24'h000003, 2'b01, 16'h0000, 1'b0, 8'hC3};
    vecs[7] = '{1'b0, 1'b1, 16'h2001, 8'h00, 0, 1, 16'h5500, 24'h001000, 2'b10, 16'h0000, 1'b0, 8'h55};

    rst = 1'b1;
    ext_address = 16'h0000; ext_read = 1'b0; ext_write = 1'b0; ext_write_data = 8'h00;
    avm_waitrequest = 1'b0; avm_readdata = 16'h0000; avm_readdatavalid = 1'b0;
    err_clr = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_ack", ext_acknowledge, 1'b0);
    chk("rst_rdata", ext_read_data, 8'h00);
    chk("rst_rd", avm_read, 1'b0);
    chk("rst_wr", avm_write, 1'b0);
    chk("rst_be", avm_byteenable, 2'b00);
    chk("rst_addr", avm_address, 24'h000000);
    chk("rst_wd", avm_writedata, 16'h0000);
    chk("rst_err", err_timeout, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Held read: one command, one ack, data stable, re-arm after a low cycle.
    a0 = ack_cnt; r0 = rd_acc;
    ext_address = 16'h0003; ext_read = 1'b1;
    tick();
    chk("hold_cmd", avm_read, 1'b1);
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 16'h7788;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 16'h0000;
    chk("hold_ack", ext_acknowledge, 1'b1);
    chk("hold_rdata", ext_read_data, 8'h77);
    stable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (ext_read_data !== 8'h77 || avm_read || ext_acknowledge) stable = 1'b0;
    end
    chk("hold_quiet", stable, 1'b1);
    chk("hold_acks", ack_cnt - a0, 1);
    chk("hold_reads", rd_acc - r0, 1);
    ext_read = 1'b0;
    tick();
    chk("hold_low_no_cmd", avm_read, 1'b0);
    ext_read = 1'b1; ext_address = 16'h0002;
    tick();
    chk("rearm_cmd", avm_read, 1'b1);
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 16'h1122;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 16'h0000;
    chk("rearm_ack", ext_acknowledge, 1'b1);
    chk("rearm_rdata", ext_read_data, 8'h22);
    ext_read = 1'b0;
    tick(); tick();

    // Timeout with err_clr held high throughout: the set must win.
    ext_address = 16'h0004; ext_read = 1'b1; err_clr = 1'b1;
    tick();
    chk("to_cmd", avm_read, 1'b1);
    tick();
    n = 0;
    while (!ext_acknowledge && n < 20) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 8);
    chk("to_rdata", ext_read_data, 8'hFF);
    chk("to_err_set_wins", err_timeout, 1'b1);
    ext_read = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("to_err_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_cleared", err_timeout, 1'b0);

    // Reset while waiting for read data.
    a0 = ack_cnt;
    ext_address = 16'h0008; ext_read = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    ext_read = 1'b0;
    rst = 1'b0;
    chk("mid_rst_rd", avm_read, 1'b0);
    chk("mid_rst_wr", avm_write, 1'b0);
    chk("mid_rst_be", avm_byteenable, 2'b00);
    chk("mid_rst_addr", avm_address, 24'h000000);
    chk("mid_rst_wd", avm_writedata, 16'h0000);
    chk("mid_rst_ack", ext_acknowledge, 1'b0);
    chk("mid_rst_rdata", ext_read_data, 8'h00);
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 16'hFFFF;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 16'h0000;
    tick();
    chk("stray_rdata", ext_read_data, 8'h00);
    chk("stray_no_ack", ack_cnt - a0, 0);
    run_vec(vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
